secuenciador_vectorial: RTL and testbench

- Parametrised successor to the combinational opcode decoder of the vector processor.
- Accepts one 4-bit opcode through a valid/ready handshake and latches its decoded control bundle.
- Vector-class instructions are then sequenced over VLEN elements in groups of LANES, one group per unstalled cycle, with an element index for the datapath.
- Sits between fetch/decode and the EXE/MEM/WB lanes; stalls on back-pressure from the memory stage.

---
 rtl/secuenciador_vectorial.sv | 175 +++++++++++++++++
 tb/tb_secuenciador_vectorial.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_vectorial.sv
// Vector instruction sequencer: accepts one opcode, latches its decoded control bundle
// and issues it over VLEN elements in groups of LANES. Optional macro: SECUENCIADOR_BACK2BACK_EN.
module secuenciador_vectorial #(
  parameter int VLEN  = 16,
  parameter int LANES = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      instr_valid,
  output logic                                      instr_ready,
  input  logic [3:0]                                opcode_in,
  input  logic                                      stall_in,
  output logic                                      group_valid,
  output logic [((VLEN > 1) ? $clog2(VLEN) : 1)-1:0] elem_idx,
  output logic                                      last_group,
  output logic [13:0]                               ctrl_out,
  output logic [3:0]                                opcode_out,
  output logic                                      busy,
  output logic                                      done
);

  localparam int NGRP  = VLEN / LANES;
  localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Bundle order: pc rdv rds dest op ad int sum_mem mem data mem_wr wb wrv wrs
  function automatic logic [13:0] decode(input logic [3:0] op);
    logic [13:0] c;
    case (op)
      4'b0000:                   c = 14'h0000;
      4'b0001, 4'b0010:          c = 14'h1006;
      4'b0011:                   c = 14'h1432;
      4'b0100:                   c = 14'h1438;
      4'b0101, 4'b1010, 4'b1011: c = 14'h1884;
      4'b0110, 4'b0111,
      4'b1000, 4'b1001:          c = 14'h1A84;
      4'b1100:                   c = 14'h0405;
      4'b1101:                   c = 14'h0905;
      4'b1110:                   c = 14'h1412;
      4'b1111:                   c = 14'h3458;
      default:                   c = 14'h0000;
    endcase
    return c;
  endfunction

  function automatic logic is_scalar(input logic [3:0] op);
    logic s;
    case (op)
      4'b0000, 4'b1100, 4'b1101, 4'b1111: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  state_t           state_r;
  logic [GRP_W-1:0] grp_r;
  logic [GRP_W-1:0] grp_inc_s;
  logic             group_valid_r;
  logic [IDX_W-1:0] elem_idx_r;
  logic             last_group_r;
  logic [13:0]      ctrl_r;
  logic [3:0]       opcode_r;
  logic             busy_r;
  logic             done_r;
  logic             instr_ready_s;
  logic             accept_s;
  logic [13:0]      dec_s;
  logic             load_last_s;

  // Handshake readiness, decode of the offered opcode and next group index
  always_comb begin
    instr_ready_s = 1'b0;
`ifdef SECUENCIADOR_BACK2BACK_EN
    if (state_r == IDLE) begin
      instr_ready_s = 1'b1;
    end else begin
      instr_ready_s = last_group_r && !stall_in;
    end
`else
    if (state_r == IDLE) begin
      instr_ready_s = 1'b1;
    end else begin
      instr_ready_s = 1'b0;
    end
`endif
    accept_s    = instr_valid && instr_ready_s;
    dec_s       = decode(opcode_in);
    load_last_s = is_scalar(opcode_in) || (GRP_LAST == {GRP_W{1'b0}});
    grp_inc_s   = grp_r + GRP_W'(1);
  end

  // Sequencer FSM with registered outputs; ctrl_out is zero outside ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      grp_r         <= {GRP_W{1'b0}};
      group_valid_r <= 1'b0;
      elem_idx_r    <= {IDX_W{1'b0}};
      last_group_r  <= 1'b0;
      ctrl_r        <= 14'h0000;
      opcode_r      <= 4'b0000;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r       <= ISSUE;
            grp_r         <= {GRP_W{1'b0}};
            group_valid_r <= 1'b1;
            elem_idx_r    <= {IDX_W{1'b0}};
            last_group_r  <= load_last_s;
            ctrl_r        <= dec_s;
            opcode_r      <= opcode_in;
            busy_r        <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (stall_in) begin
            state_r <= ISSUE;
          end else if (last_group_r) begin
            done_r <= 1'b1;
            if (accept_s) begin
              // Back-to-back: next instruction starts without a bubble
              state_r       <= ISSUE;
              grp_r         <= {GRP_W{1'b0}};
              group_valid_r <= 1'b1;
              elem_idx_r    <= {IDX_W{1'b0}};
              last_group_r  <= load_last_s;
              ctrl_r        <= dec_s;
              opcode_r      <= opcode_in;
              busy_r        <= 1'b1;
            end else begin
              state_r       <= IDLE;
              grp_r         <= {GRP_W{1'b0}};
              group_valid_r <= 1'b0;
              elem_idx_r    <= {IDX_W{1'b0}};
              last_group_r  <= 1'b0;
              ctrl_r        <= 14'h0000;
              busy_r        <= 1'b0;
            end
          end else begin
            grp_r        <= grp_inc_s;
            elem_idx_r   <= elem_idx_r + IDX_STEP;
            last_group_r <= (grp_inc_s == GRP_LAST);
          end
        end
        default: begin
          state_r       <= IDLE;
          group_valid_r <= 1'b0;
          ctrl_r        <= 14'h0000;
          busy_r        <= 1'b0;
          last_group_r  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_s;
  assign group_valid = group_valid_r;
  assign elem_idx    = elem_idx_r;
  assign last_group  = last_group_r;
  assign ctrl_out    = ctrl_r;
  assign opcode_out  = opcode_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_secuenciador_vectorial.sv
// Directed self-checking bench for secuenciador_vectorial (VLEN=16, LANES=4).
module tb_secuenciador_vectorial;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode_in;
  logic        stall_in;
  logic        group_valid;
  logic [3:0]  elem_idx;
  logic        last_group;
  logic [13:0] ctrl_out;
  logic [3:0]  opcode_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  secuenciador_vectorial #(.VLEN(16), .LANES(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode_in(opcode_in), .stall_in(stall_in), .group_valid(group_valid),
    .elem_idx(elem_idx), .last_group(last_group), .ctrl_out(ctrl_out),
    .opcode_out(opcode_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; opcode_in = 4'b0000; stall_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({group_valid, elem_idx, last_group, ctrl_out, opcode_out, busy, done, instr_ready} !==
        {1'b0, 4'd0, 1'b0, 14'h0000, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: gv=%b idx=%0d last=%b ctrl=%h op=%h busy=%b done=%b rdy=%b, want all 0 and rdy=1",
               group_valid, elem_idx, last_group, ctrl_out, opcode_out, busy, done, instr_ready);
    end
  endtask

  task automatic test_vector_basic();
    instr_valid = 1'b1; opcode_in = 4'b0001;
    tick();
    instr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({group_valid, elem_idx, last_group, ctrl_out[1], ctrl_out, busy, done} !==
          {1'b1, 4'(k * 4), (k == 3), 1'b1, 14'h1006, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL vec_group%0d: gv=%b idx=%0d last=%b ctrl=%h busy=%b done=%b, want gv=1 idx=%0d last=%b ctrl=1006 busy=1 done=0",
                 k, group_valid, elem_idx, last_group, ctrl_out, busy, done, k * 4, (k == 3));
      end
      tick();
    end
    n_checks++;
    if ({done, instr_ready, group_valid, ctrl_out, busy} !== {1'b1, 1'b1, 1'b0, 14'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL vec_done: done=%b rdy=%b gv=%b ctrl=%h busy=%b, want done=1 rdy=1 gv=0 ctrl=0 busy=0",
               done, instr_ready, group_valid, ctrl_out, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_idx [1:6];
    exp_idx = '{4'd0, 4'd4, 4'd4, 4'd4, 4'd8, 4'd12};
    instr_valid = 1'b1; opcode_in = 4'b0100;
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      stall_in = (c == 2) || (c == 3);
      n_checks++;
      if ({group_valid, elem_idx, last_group, ctrl_out, ctrl_out[3]} !==
          {1'b1, exp_idx[c], (c == 6), 14'h1438, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: gv=%b idx=%0d last=%b ctrl=%h, want gv=1 idx=%0d last=%b ctrl=1438",
                 c, group_valid, elem_idx, last_group, ctrl_out, exp_idx[c], (c == 6));
      end
      tick();
    end
    stall_in = 1'b0;
    n_checks++;
    if ({done, group_valid, ctrl_out[3]} !== {1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_done: done=%b gv=%b mem_wr=%b, want done=1 gv=0 mem_wr=0",
               done, group_valid, ctrl_out[3]);
    end
    tick();
  endtask

  task automatic test_scalar();
    instr_valid = 1'b1; opcode_in = 4'b1101;
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if ({group_valid, elem_idx, last_group, ctrl_out, opcode_out} !==
        {1'b1, 4'd0, 1'b1, 14'b00_1001_0000_0101, 4'b1101}) begin
      n_fail++;
      $display("FAIL scalar_group: gv=%b idx=%0d last=%b ctrl=%h op=%h, want gv=1 idx=0 last=1 ctrl=0905 op=d",
               group_valid, elem_idx, last_group, ctrl_out, opcode_out);
    end
    tick();
    n_checks++;
    if ({done, group_valid} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL scalar_done: done=%b gv=%b, want done=1 gv=0", done, group_valid);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    instr_valid = 1'b1; opcode_in = 4'b0011;
    tick();
    instr_valid = 1'b0;
    tick();
    n_checks++;
    if ({group_valid, elem_idx, ctrl_out} !== {1'b1, 4'd4, 14'h1432}) begin
      n_fail++;
      $display("FAIL midrst_second_group: gv=%b idx=%0d ctrl=%h, want gv=1 idx=4 ctrl=1432",
               group_valid, elem_idx, ctrl_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({group_valid, elem_idx, last_group, ctrl_out, opcode_out, busy, done, instr_ready} !==
        {1'b0, 4'd0, 1'b0, 14'h0000, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_cleared: gv=%b idx=%0d last=%b ctrl=%h op=%h busy=%b done=%b rdy=%b, want all 0 and rdy=1",
               group_valid, elem_idx, last_group, ctrl_out, opcode_out, busy, done, instr_ready);
    end
    tick();
    n_checks++;
    if ({done, group_valid} !== {1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_no_done: done=%b gv=%b, want done=0 gv=0", done, group_valid);
    end
  endtask

  task automatic test_back_to_back();
    int  acc;
    bit  take;
    bit  exp_gv;
    bit  exp_done;
    logic [3:0] exp_idx;
    acc = 0;
    instr_valid = 1'b1; opcode_in = 4'b0001;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
`ifdef SECUENCIADOR_BACK2BACK_EN
        exp_gv   = (c <= 8);
        exp_idx  = exp_gv ? 4'(((c - 1) % 4) * 4) : 4'd0;
        exp_done = (c == 5) || (c == 9);
`else
        exp_gv   = (c <= 4) || (c >= 6 && c <= 9);
        exp_idx  = (c <= 4) ? 4'((c - 1) * 4) : ((c >= 6 && c <= 9) ? 4'((c - 6) * 4) : 4'd0);
        exp_done = (c == 5) || (c == 10);
`endif
        n_checks++;
        if ({group_valid, elem_idx, done} !== {exp_gv, exp_idx, exp_done}) begin
          n_fail++;
          $display("FAIL b2b_cycle%0d: gv=%b idx=%0d done=%b, want gv=%b idx=%0d done=%b",
                   c, group_valid, elem_idx, done, exp_gv, exp_idx, exp_done);
        end
      end
      take = instr_valid && instr_ready;
      tick();
      if (take) begin
        acc++;
        if (acc == 2) instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    n_checks++;
    if (acc !== 2) begin
      n_fail++;
      $display("FAIL b2b_accepts: accepted=%0d, want 2", acc);
    end
    tick();
  endtask

  task automatic test_nop();
    instr_valid = 1'b1; opcode_in = 4'b0000;
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if ({group_valid, ctrl_out, last_group, elem_idx} !== {1'b1, 14'h0000, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL nop_group: gv=%b ctrl=%h last=%b idx=%0d, want gv=1 ctrl=0 last=1 idx=0",
               group_valid, ctrl_out, last_group, elem_idx);
    end
    tick();
    n_checks++;
    if ({done, group_valid} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL nop_done: done=%b gv=%b, want done=1 gv=0", done, group_valid);
    end
    tick();
  endtask

  task automatic test_decode();
    logic [3:0]  ops  [5];
    logic [13:0] exps [5];
    bit          seen;
    ops  = '{4'b0111, 4'b1010, 4'b1100, 4'b1110, 4'b1111};
    exps = '{14'h1A84, 14'h1884, 14'h0405, 14'h1412, 14'h3458};
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1; opcode_in = ops[i];
      tick();
      instr_valid = 1'b0;
      n_checks++;
      if ({ctrl_out, opcode_out} !== {exps[i], ops[i]}) begin
        n_fail++;
        $display("FAIL decode_%b: ctrl=%h op=%h, want ctrl=%h op=%h",
                 ops[i], ctrl_out, opcode_out, exps[i], ops[i]);
      end
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        tick();
        if (done === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b1) begin
        n_fail++;
        $display("FAIL decode_%b_done: done not seen within 10 cycles, want done pulse", ops[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_vector_basic();
    test_stall();
    test_scalar();
    test_reset_midflight();
    test_back_to_back();
    test_nop();
    test_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
